// File: rtl/vga_timing_gen_if.sv
// Video output bundle of the VGA timing generator, plus its run-time pattern controls.
// Master = generator (drives sync/de/colour/coordinates, reads controls); slave = sink.
// Purely combinational wiring; no flow control, one pixel per clock.
interface vga_timing_gen_if #(
    parameter int COLOR_W = 4,
    parameter int CNT_W   = 12
);
    // run-time pattern controls
    logic [1:0]           mode;
    logic [3*COLOR_W-1:0] solid_rgb;

    // video timing and pixel outputs
    logic                 vga_hs;
    logic                 vga_vs;
    logic                 vga_de;
    logic [COLOR_W-1:0]   vga_r;
    logic [COLOR_W-1:0]   vga_g;
    logic [COLOR_W-1:0]   vga_b;
    logic [CNT_W-1:0]     pix_x;
    logic [CNT_W-1:0]     pix_y;
    logic                 frame_start;
    logic                 line_start;

    modport master (
        input  mode,
        input  solid_rgb,
        output vga_hs,
        output vga_vs,
        output vga_de,
        output vga_r,
        output vga_g,
        output vga_b,
        output pix_x,
        output pix_y,
        output frame_start,
        output line_start
    );

    modport slave (
        output mode,
        output solid_rgb,
        input  vga_hs,
        input  vga_vs,
        input  vga_de,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  pix_x,
        input  pix_y,
        input  frame_start,
        input  line_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync / data-enable / coordinate generator with run-time RGB test patterns.
// Latency: every output is registered once from the h/v counters (1 clock), all mutually aligned.
// Backpressure: none; free-running at one pixel per clock. Optional border overlay: VGA_BORDER_EN.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int COLOR_W   = 4,
    parameter int CHK_SHIFT = 4,
    parameter int CNT_W     = 12
) (
    input  logic                    clk_pix,
    input  logic                    rst,
    vga_timing_gen_if.master        vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] BAR_LAST   = CNT_W'(BAR_W - 1);
`ifdef VGA_BORDER_EN
    localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
`endif

    localparam logic [1:0] MODE_BARS  = 2'd0;
    localparam logic [1:0] MODE_CHK   = 2'd1;
    localparam logic [1:0] MODE_GRAD  = 2'd2;
    localparam logic [1:0] MODE_SOLID = 2'd3;

    // raster position; only ever 0..TOTAL-1
    logic [CNT_W-1:0]     h_cnt;
    logic [CNT_W-1:0]     v_cnt;

    // bar index for the current h_cnt, tracked incrementally to avoid a divider
    logic [2:0]           bar_idx;
    logic [CNT_W-1:0]     bar_pix;

    // pattern controls, frozen for a whole frame
    logic [1:0]           mode_q;
    logic [3*COLOR_W-1:0] solid_q;

    // combinational decode of the current raster position
    logic                 frame_origin;
    logic                 line_end;
    logic                 hs_act;
    logic                 vs_act;
    logic                 de_act;
    logic [1:0]           mode_eff;
    logic [3*COLOR_W-1:0] solid_eff;
    logic                 chk_bit;
    logic [COLOR_W-1:0]   pat_r;
    logic [COLOR_W-1:0]   pat_g;
    logic [COLOR_W-1:0]   pat_b;

    // Position decode: sync windows, active area and frame origin.
    always_comb begin
        frame_origin = (h_cnt == '0) && (v_cnt == '0);
        line_end     = (h_cnt == H_LAST);
        hs_act       = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs_act       = (v_cnt >= VS_START) && (v_cnt < VS_END);
        de_act       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    end

    // Raster counters, bar tracker and the once-per-frame control latch.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            bar_idx <= '0;
            bar_pix <= '0;
            mode_q  <= '0;
            solid_q <= '0;
        end else begin
            if (line_end) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end

            // bar index saturates at 7; beyond the active area it is masked by de anyway
            if (line_end) begin
                bar_idx <= '0;
                bar_pix <= '0;
            end else if (bar_pix == BAR_LAST) begin
                bar_pix <= '0;
                if (bar_idx != 3'd7) begin
                    bar_idx <= bar_idx + 3'd1;
                end
            end else begin
                bar_pix <= bar_pix + 1'b1;
            end

            if (frame_origin) begin
                mode_q  <= vid.mode;
                solid_q <= vid.solid_rgb;
            end
        end
    end

    // Pattern generation. At the frame origin the freshly sampled controls are
    // used directly so the new mode starts exactly on the frame_start pixel.
    always_comb begin
        mode_eff  = frame_origin ? vid.mode      : mode_q;
        solid_eff = frame_origin ? vid.solid_rgb : solid_q;
        chk_bit   = h_cnt[CHK_SHIFT] ^ v_cnt[CHK_SHIFT];
        pat_r     = '0;
        pat_g     = '0;
        pat_b     = '0;
        case (mode_eff)
            MODE_BARS: begin
                // white, yellow, cyan, green, magenta, red, blue, black
                pat_r = {COLOR_W{~bar_idx[1]}};
                pat_g = {COLOR_W{~bar_idx[2]}};
                pat_b = {COLOR_W{~bar_idx[0]}};
            end
            MODE_CHK: begin
                pat_r = {COLOR_W{chk_bit}};
                pat_g = {COLOR_W{chk_bit}};
                pat_b = {COLOR_W{chk_bit}};
            end
            MODE_GRAD: begin
                pat_r = h_cnt[COLOR_W-1:0];
                pat_g = v_cnt[COLOR_W-1:0];
                pat_b = h_cnt[COLOR_W-1:0] ^ v_cnt[COLOR_W-1:0];
            end
            MODE_SOLID: begin
                {pat_r, pat_g, pat_b} = solid_eff;
            end
            default: begin
                pat_r = '0;
                pat_g = '0;
                pat_b = '0;
            end
        endcase
`ifdef VGA_BORDER_EN
        // one-pixel white frame around the visible area, on top of any pattern
        if ((h_cnt == '0) || (h_cnt == H_ACT_LAST) ||
            (v_cnt == '0) || (v_cnt == V_ACT_LAST)) begin
            pat_r = '1;
            pat_g = '1;
            pat_b = '1;
        end
`endif
        if (!de_act) begin
            pat_r = '0;
            pat_g = '0;
            pat_b = '0;
        end
    end

    // Output register stage: everything reflects the same counter snapshot.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            vid.vga_hs      <= ~HS_POL;
            vid.vga_vs      <= ~VS_POL;
            vid.vga_de      <= 1'b0;
            vid.vga_r       <= '0;
            vid.vga_g       <= '0;
            vid.vga_b       <= '0;
            vid.pix_x       <= '0;
            vid.pix_y       <= '0;
            vid.frame_start <= 1'b0;
            vid.line_start  <= 1'b0;
        end else begin
            vid.vga_hs      <= hs_act ? HS_POL : ~HS_POL;
            vid.vga_vs      <= vs_act ? VS_POL : ~VS_POL;
            vid.vga_de      <= de_act;
            vid.vga_r       <= pat_r;
            vid.vga_g       <= pat_g;
            vid.vga_b       <= pat_b;
            vid.pix_x       <= h_cnt;
            vid.pix_y       <= v_cnt;
            vid.frame_start <= frame_origin;
            vid.line_start  <= (h_cnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a tiny raster (H 16/2/3/3, V 4/1/2/1 => 24 x 8 = 192 clocks/frame).
// A behavioural model pushes the expected output word per clock into a queue; tasks pop and compare.
// Build with VGA_BORDER_EN defined to also cover the border overlay.
module tb_vga_timing_gen;

    localparam int COLOR_W = 4;
    localparam int CNT_W   = 8;
    localparam int HT      = 24;
    localparam int VT      = 8;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic [7:0] x;
        logic [7:0] y;
        logic       fs;
        logic       ls;
    } vout_t;

    logic  clk_pix = 1'b0;
    logic  rst     = 1'b1;
    vout_t exp_q[$];
    vout_t obs;
    vout_t e;
    int    checks  = 0;
    int    passes  = 0;
    int    fails   = 0;
    int    cyc     = 0;

    // model state
    int         m_h = 0;
    int         m_v = 0;
    logic [1:0] m_mode = 2'd0;
    logic [11:0] m_solid = 12'h000;

    vga_timing_gen_if #(.COLOR_W(COLOR_W), .CNT_W(CNT_W)) vid ();

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0),
        .COLOR_W(COLOR_W), .CHK_SHIFT(1), .CNT_W(CNT_W)
    ) dut (
        .clk_pix (clk_pix),
        .rst     (rst),
        .vid     (vid)
    );

    always #5 clk_pix = ~clk_pix;

    // Model one clock: push the expected output for this edge, advance, then sample #1 later.
    task automatic tick();
        vout_t      x;
        logic [3:0] r, g, b;
        logic       de;
        int         bar;
        x = '0;
        if (rst) begin
            x.hs = 1'b1;
            x.vs = 1'b1;
            m_h = 0; m_v = 0; m_mode = 2'd0; m_solid = 12'h000;
        end else begin
            de = (m_h < 16) && (m_v < 4);
            if (m_h == 0 && m_v == 0) begin
                m_mode  = vid.mode;
                m_solid = vid.solid_rgb;
            end
            r = 4'h0; g = 4'h0; b = 4'h0;
            case (m_mode)
                2'd0: begin
                    bar = m_h / 2;
                    r = (bar == 0 || bar == 1 || bar == 4 || bar == 5) ? 4'hF : 4'h0;
                    g = (bar < 4) ? 4'hF : 4'h0;
                    b = (bar % 2 == 0) ? 4'hF : 4'h0;
                end
                2'd1: begin
                    r = ((((m_h / 2) + (m_v / 2)) % 2) == 1) ? 4'hF : 4'h0;
                    g = r;
                    b = r;
                end
                2'd2: begin
                    r = 4'(m_h % 16);
                    g = 4'(m_v % 16);
                    b = r ^ g;
                end
                default: {r, g, b} = m_solid;
            endcase
`ifdef VGA_BORDER_EN
            if (m_h == 0 || m_h == 15 || m_v == 0 || m_v == 3) begin
                r = 4'hF; g = 4'hF; b = 4'hF;
            end
`endif
            if (!de) begin
                r = 4'h0; g = 4'h0; b = 4'h0;
            end
            x.hs = !(m_h >= 18 && m_h < 21);
            x.vs = !(m_v >= 5 && m_v < 7);
            x.de = de;
            x.r  = r; x.g = g; x.b = b;
            x.x  = 8'(m_h);
            x.y  = 8'(m_v);
            x.fs = (m_h == 0) && (m_v == 0);
            x.ls = (m_h == 0);
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end
        exp_q.push_back(x);
        @(posedge clk_pix);
        #1;
        cyc++;
        obs.hs = vid.vga_hs; obs.vs = vid.vga_vs; obs.de = vid.vga_de;
        obs.r  = vid.vga_r;  obs.g  = vid.vga_g;  obs.b  = vid.vga_b;
        obs.x  = vid.pix_x;  obs.y  = vid.pix_y;
        obs.fs = vid.frame_start; obs.ls = vid.line_start;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vid.mode = 2'd0;
        vid.solid_rgb = 12'h000;
        for (int i = 0; i < 3; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                fails++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs, e);
            end else passes++;
        end
    endtask

    // Release reset; check per-clock output plus frame/line periods, de, hs and vs counts.
    task automatic test_timing();
        int fs_first, fs_second, ls_prev, ls_gap_bad, de_cnt, hs_cnt, vs_cnt;
        fs_first = -1; fs_second = -1; ls_prev = -1; ls_gap_bad = 0;
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        rst = 1'b0;
        for (int i = 0; i < 2 * HT * VT + 4; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                fails++;
                $display("FAIL timing cyc=%0d got=%h exp=%h", cyc, obs, e);
            end else passes++;
            if (i == 0) begin
                checks++;
                if (obs.fs !== 1'b1 || obs.ls !== 1'b1 || obs.de !== 1'b1) begin
                    fails++;
                    $display("FAIL first_pixel fs/ls/de got=%b%b%b exp=111", obs.fs, obs.ls, obs.de);
                end else passes++;
            end
            if (obs.fs === 1'b1) begin
                if (fs_first < 0) fs_first = i;
                else if (fs_second < 0) fs_second = i;
            end
            if (obs.ls === 1'b1) begin
                if (ls_prev >= 0 && (i - ls_prev) != HT) ls_gap_bad++;
                ls_prev = i;
            end
            if (i < HT * VT) begin
                if (obs.de === 1'b1) de_cnt++;
                if (obs.hs === 1'b0) hs_cnt++;
                if (obs.vs === 1'b0) vs_cnt++;
            end
        end
        checks++;
        if (fs_second - fs_first != 192) begin
            fails++;
            $display("FAIL frame_period got=%0d exp=192", fs_second - fs_first);
        end else passes++;
        checks++;
        if (ls_gap_bad != 0) begin
            fails++;
            $display("FAIL line_period bad_gaps=%0d exp=0", ls_gap_bad);
        end else passes++;
        checks++;
        if (de_cnt != 64) begin
            fails++;
            $display("FAIL de_per_frame got=%0d exp=64", de_cnt);
        end else passes++;
        checks++;
        if (hs_cnt != 24 || vs_cnt != 48) begin
            fails++;
            $display("FAIL sync_widths hs=%0d vs=%0d exp=24/48", hs_cnt, vs_cnt);
        end else passes++;
    endtask

    // Colour bars on line 0 against a literal table, one entry per 2-pixel bar.
    task automatic test_bars();
        logic [11:0] tbl [8];
        logic [11:0] want;
        tbl = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        while (m_h != 0 || m_v != 0) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                fails++;
                $display("FAIL bars_align cyc=%0d got=%h exp=%h", cyc, obs, e);
            end else passes++;
        end
        for (int i = 0; i < HT; i++) begin
            tick();
            e = exp_q.pop_front();
            want = (i < 16) ? tbl[i / 2] : 12'h000;
`ifdef VGA_BORDER_EN
            if (i < 16) want = 12'hFFF;
`endif
            checks++;
            if ({obs.r, obs.g, obs.b} !== want || obs !== e) begin
                fails++;
                $display("FAIL bars x=%0d rgb=%h exp=%h word=%h expword=%h",
                         i, {obs.r, obs.g, obs.b}, want, obs, e);
            end else passes++;
        end
    endtask

    // Switch to solid 5A3 mid-frame: bars continue until next frame_start, then solid.
    task automatic test_mode_change();
        int seen_fs;
        seen_fs = 0;
        vid.mode = 2'd3;
        vid.solid_rgb = 12'h5A3;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                fails++;
                $display("FAIL mode_change cyc=%0d got=%h exp=%h", cyc, obs, e);
            end else passes++;
            if (obs.fs === 1'b1) seen_fs++;
            if (seen_fs == 0 && obs.x == 8'd2 && obs.y == 8'd1) begin
                checks++;
                if ({obs.r, obs.g, obs.b} !== 12'hFF0) begin
                    fails++;
                    $display("FAIL still_bars rgb=%h exp=ff0", {obs.r, obs.g, obs.b});
                end else passes++;
            end
            if (seen_fs == 1 && obs.x == 8'd5 && obs.y == 8'd1) begin
                checks++;
                if ({obs.r, obs.g, obs.b} !== 12'h5A3) begin
                    fails++;
                    $display("FAIL solid rgb=%h exp=5a3", {obs.r, obs.g, obs.b});
                end else passes++;
            end
        end
    endtask

    // One full frame each of checker and gradient (mode is taken at the next frame origin).
    task automatic test_patterns();
        for (int p = 1; p <= 2; p++) begin
            vid.mode = 2'(p);
            for (int i = 0; i < 2 * HT * VT; i++) begin
                tick();
                e = exp_q.pop_front();
                checks++;
                if (obs !== e) begin
                    fails++;
                    $display("FAIL pattern%0d cyc=%0d got=%h exp=%h", p, cyc, obs, e);
                end else passes++;
            end
        end
    endtask

    // One-clock reset at x=10, y=2, then a clean full frame.
    task automatic test_reset_mid();
        int guard, fs_at;
        guard = 0;
        fs_at = -1;
        vid.mode = 2'd0;
        while (!(m_h == 10 && m_v == 2) && guard < 400) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                fails++;
                $display("FAIL pre_reset cyc=%0d got=%h exp=%h", cyc, obs, e);
            end else passes++;
            guard++;
        end
        checks++;
        if (guard >= 400) begin
            fails++;
            $display("FAIL reset_mid_reach x=%0d y=%0d exp=10/2", m_h, m_v);
        end else passes++;
        rst = 1'b1;
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e || obs !== {1'b1, 1'b1, 1'b0, 12'h000, 8'd0, 8'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_mid got=%h exp=%h", obs, e);
        end else passes++;
        rst = 1'b0;
        for (int i = 0; i <= HT * VT; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                fails++;
                $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, obs, e);
            end else passes++;
            if (i > 0 && obs.fs === 1'b1 && fs_at < 0) fs_at = i;
            if (i == 0) begin
                checks++;
                if (obs.fs !== 1'b1) begin
                    fails++;
                    $display("FAIL restart_fs got=%b exp=1", obs.fs);
                end else passes++;
            end
        end
        checks++;
        if (fs_at != 192) begin
            fails++;
            $display("FAIL restart_period got=%0d exp=192", fs_at);
        end else passes++;
    endtask

    // Solid black frame: only the border (when enabled) lights up.
    task automatic test_solid_black();
        vid.mode = 2'd3;
        vid.solid_rgb = 12'h000;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                fails++;
                $display("FAIL solid_black cyc=%0d got=%h exp=%h", cyc, obs, e);
            end else passes++;
        end
    endtask

    initial begin
        vid.mode = 2'd0;
        vid.solid_rgb = 12'h000;
        test_reset();
        test_timing();
        test_bars();
        test_mode_change();
        test_patterns();
        test_reset_mid();
        test_solid_black();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
